zjh_74hc148_irq_enc: RTL and testbench

- Registered 8-to-3 priority encoder: the encoding-side counterpart of the 74HC138-style 3-to-8 decoder in this design.
- Takes eight active-low request lines in 74HC148 pin sense, with I_n[7] the highest priority.
- Synchronises the requests, latches falling edges as pending requests, and presents the highest pending index as a stable active-low code.
- The consumer takes each code with a valid/ack handshake. The block sits between asynchronous board-level request pins and the clocked control logic.

---
 rtl/zjh_74hc148_irq_enc_pkg.sv | 15 +
 rtl/zjh_sync_fall.sv | 29 ++
 rtl/zjh_74hc148_irq_enc.sv | 97 +++++++++
 tb/tb_zjh_74hc148_irq_enc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/zjh_74hc148_irq_enc_pkg.sv
// Shared constants and types for the 74HC148-style registered priority encoder.
//   N_REQ   : number of request lines
//   CODE_W  : width of the encoded index
//   A_IDLE  : active-low code driven when nothing is presented
//   state_t : handshake state (IDLE / PRESENT)
package zjh_74hc148_irq_enc_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] A_IDLE = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/zjh_sync_fall.sv
// Single-bit synchroniser followed by a falling-edge pulse generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset; all flops go to 1 (inactive)
//   d    : asynchronous active-low request input
//   fall : one-cycle pulse when the synchronised input goes 1 -> 0
module zjh_sync_fall #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // hist holds last cycle's synchronised value, so this is high for exactly one cycle.
    assign fall = hist_q & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/zjh_74hc148_irq_enc.sv
// Registered 8-to-3 priority encoder with edge-latched pending requests and a
// valid/ack handshake toward the consumer.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   EI_n : active-low enable; high defers launching a new code
//   I_n  : active-low asynchronous requests, I_n[7] highest priority
//   ack  : consumer accepts the presented code (only while GS_n=0)
//   A_n  : active-low index of the presented request, 3'b111 when none
//   GS_n : active-low code valid
//   EO_n : active-low "enabled and completely idle"
//   ovf  : sticky, a request re-fired while already pending
module zjh_74hc148_irq_enc
    import zjh_74hc148_irq_enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EI_n,
    input  logic [N_REQ-1:0]  I_n,
    input  logic              ack,
    output logic [CODE_W-1:0] A_n,
    output logic              GS_n,
    output logic              EO_n,
    output logic              ovf
);
    logic [N_REQ-1:0]  fall;
    logic [N_REQ-1:0]  pending_q, pending_nx, clr_mask;
    logic [CODE_W-1:0] code_q, code_nx;
    state_t            state_q, state_nx;
    logic              clr;
    logic              ovf_nx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_sync
        zjh_sync_fall #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (I_n[k]),
            .fall (fall[k])
        );
    end

    function automatic logic [CODE_W-1:0] pick_hi(input logic [N_REQ-1:0] p);
        pick_hi = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (p[i]) pick_hi = CODE_W'(i);
        end
    endfunction

    always_comb begin
        state_nx = state_q;
        code_nx  = code_q;
        clr      = 1'b0;
        case (state_q)
            IDLE: begin
                // Priority is only evaluated here; PRESENT holds the code frozen.
                if (!EI_n && (pending_q != '0)) begin
                    state_nx = PRESENT;
                    code_nx  = pick_hi(pending_q);
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Set is OR-ed in after the clear so a same-cycle re-fire survives the ack.
    assign clr_mask   = clr ? (N_REQ'(1) << code_q) : '0;
    assign pending_nx = (pending_q & ~clr_mask) | fall;
    assign ovf_nx     = ovf | (|(fall & pending_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            ovf       <= 1'b0;
            A_n       <= A_IDLE;
            GS_n      <= 1'b1;
            EO_n      <= 1'b1;
        end else begin
            state_q   <= state_nx;
            code_q    <= code_nx;
            pending_q <= pending_nx;
            ovf       <= ovf_nx;
            A_n       <= (state_nx == PRESENT) ? ~code_nx : A_IDLE;
            GS_n      <= (state_nx != PRESENT);
            // Uses the pending set seen this cycle, so EO_n trails a final ack by one cycle.
            EO_n      <= !(!EI_n && (pending_q == '0) && (state_nx == IDLE));
        end
    end
endmodule

// File: tb/tb_zjh_74hc148_irq_enc.sv
module tb_zjh_74hc148_irq_enc;
    logic       clk = 1'b0;
    logic       rst;
    logic       EI_n;
    logic [7:0] I_n;
    logic       ack;
    logic [2:0] A_n;
    logic       GS_n;
    logic       EO_n;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    zjh_74hc148_irq_enc #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .EI_n (EI_n),
        .I_n  (I_n),
        .ack  (ack),
        .A_n  (A_n),
        .GS_n (GS_n),
        .EO_n (EO_n),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land 1 ns after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; EI_n = 1'b0; I_n = 8'h00; ack = 1'b0;
        step(3);
        checks++; if (A_n !== 3'b111) begin errors++; $display("FAIL reset_A_n got=%b exp=111", A_n); end
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL reset_GS_n got=%b exp=1", GS_n); end
        checks++; if (EO_n !== 1'b1) begin errors++; $display("FAIL reset_EO_n got=%b exp=1", EO_n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst = 1'b0; I_n = 8'hFF;
        step(3);
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL release_EO_n got=%b exp=0", EO_n); end
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL release_GS_n got=%b exp=1", GS_n); end
    endtask

    task automatic test_single();
        I_n = 8'hDF;   // index 5 low
        step(3);
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL single_early_GS_n got=%b exp=1", GS_n); end
        step(1);
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL single_GS_n got=%b exp=0", GS_n); end
        checks++; if (A_n !== 3'b010) begin errors++; $display("FAIL single_A_n got=%b exp=010", A_n); end
        checks++; if (EO_n !== 1'b1) begin errors++; $display("FAIL single_EO_n_busy got=%b exp=1", EO_n); end
        step(2);
        checks++; if (A_n !== 3'b010) begin errors++; $display("FAIL single_hold_A_n got=%b exp=010", A_n); end
        ack_pulse();
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL single_ack_GS_n got=%b exp=1", GS_n); end
        checks++; if (A_n !== 3'b111) begin errors++; $display("FAIL single_ack_A_n got=%b exp=111", A_n); end
        checks++; if (EO_n !== 1'b1) begin errors++; $display("FAIL single_ack_EO_n got=%b exp=1", EO_n); end
        step(1);
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL single_EO_n got=%b exp=0", EO_n); end
        // Held-low line must not re-request.
        step(4);
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL single_level_GS_n got=%b exp=1", GS_n); end
        I_n = 8'hFF;
        step(4);
    endtask

    task automatic test_simultaneous();
        I_n = 8'hBB;   // indices 6 and 2 low
        step(4);
        checks++; if (A_n !== 3'b001) begin errors++; $display("FAIL simul_first_A_n got=%b exp=001", A_n); end
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL simul_first_GS_n got=%b exp=0", GS_n); end
        ack_pulse();
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL simul_gap_GS_n got=%b exp=1", GS_n); end
        step(1);
        checks++; if (A_n !== 3'b101) begin errors++; $display("FAIL simul_second_A_n got=%b exp=101", A_n); end
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL simul_second_GS_n got=%b exp=0", GS_n); end
        ack_pulse();
        step(1);
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL simul_EO_n got=%b exp=0", EO_n); end
        I_n = 8'hFF;
        step(4);
    endtask

    task automatic test_hold_present();
        I_n = 8'hF7;   // index 3
        step(4);
        checks++; if (A_n !== 3'b100) begin errors++; $display("FAIL hold_first_A_n got=%b exp=100", A_n); end
        I_n = 8'h77;   // add index 7
        step(5);
        checks++; if (A_n !== 3'b100) begin errors++; $display("FAIL hold_frozen_A_n got=%b exp=100", A_n); end
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL hold_frozen_GS_n got=%b exp=0", GS_n); end
        // ack in IDLE must be ignored: check after the handshake path too.
        ack_pulse();
        step(1);
        checks++; if (A_n !== 3'b000) begin errors++; $display("FAIL hold_next_A_n got=%b exp=000", A_n); end
        ack_pulse();
        ack_pulse();   // lands in IDLE, no effect
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL hold_EO_n got=%b exp=0", EO_n); end
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL hold_idle_ack_GS_n got=%b exp=1", GS_n); end
        I_n = 8'hFF;
        step(4);
    endtask

    task automatic test_enable_ovf();
        EI_n = 1'b1;
        I_n = 8'hFD; step(4);
        I_n = 8'hFF; step(4);
        I_n = 8'hFD; step(4);
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL en_GS_n got=%b exp=1", GS_n); end
        checks++; if (EO_n !== 1'b1) begin errors++; $display("FAIL en_EO_n got=%b exp=1", EO_n); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL en_ovf got=%b exp=1", ovf); end
        EI_n = 1'b0;
        step(1);
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL en_launch_GS_n got=%b exp=0", GS_n); end
        checks++; if (A_n !== 3'b110) begin errors++; $display("FAIL en_launch_A_n got=%b exp=110", A_n); end
        ack_pulse();
        step(2);
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL en_single_GS_n got=%b exp=1", GS_n); end
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL en_idle_EO_n got=%b exp=0", EO_n); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL en_sticky_ovf got=%b exp=1", ovf); end
        I_n = 8'hFF;
        step(4);
    endtask

    task automatic test_reset_mid();
        I_n = 8'hEF;   // one-cycle pulse on index 4
        step(1);
        I_n = 8'hFF;
        step(3);
        checks++; if (GS_n !== 1'b0) begin errors++; $display("FAIL mid_pre_GS_n got=%b exp=0", GS_n); end
        checks++; if (A_n !== 3'b011) begin errors++; $display("FAIL mid_pre_A_n got=%b exp=011", A_n); end
        #2 rst = 1'b1;
        #1;
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL mid_async_GS_n got=%b exp=1", GS_n); end
        checks++; if (A_n !== 3'b111) begin errors++; $display("FAIL mid_async_A_n got=%b exp=111", A_n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_async_ovf got=%b exp=0", ovf); end
        step(1);
        rst = 1'b0;
        step(6);
        checks++; if (GS_n !== 1'b1) begin errors++; $display("FAIL mid_after_GS_n got=%b exp=1", GS_n); end
        checks++; if (EO_n !== 1'b0) begin errors++; $display("FAIL mid_after_EO_n got=%b exp=0", EO_n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_hold_present();
        test_enable_ovf();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
